// File: rtl/ravenoc_pkg.sv
// rtl/ravenoc_pkg.sv - shared NoC constants and TX scheduler state type
package ravenoc_pkg;

    localparam int FlitDataWidth = 32;
    localparam int PktWidth      = 8;
    localparam int NumVirtChn    = 3;

    typedef enum logic {
        TX_IDLE,
        TX_BURST
    } tx_sched_st_t;

endpackage

// File: rtl/ni_vc_arbiter.sv
// rtl/ni_vc_arbiter.sv - VC grant selection: fixed highest-index priority, or round-robin when TX_SCHED_RR_EN is defined
module ni_vc_arbiter #(
    parameter int NumVC = 3,
    localparam int VcW = (NumVC > 1) ? $clog2(NumVC) : 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [NumVC-1:0] req,
    input  logic             update,
    input  logic [VcW-1:0]   upd_idx,
    output logic [NumVC-1:0] grant,
    output logic [VcW-1:0]   idx
);

`ifdef TX_SCHED_RR_EN
    logic [VcW-1:0] rr_ptr;
    logic           found;
    int             cand;

    // Pointer moves just past the VC whose packet has completed.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rr_ptr <= '0;
        end else if (update) begin
            if (int'(upd_idx) == NumVC - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= upd_idx + 1'b1;
            end
        end
    end

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NumVC; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NumVC) begin
                cand = cand - NumVC;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = VcW'(cand);
            end
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, arst, update, upd_idx};

    always_comb begin
        idx = '0;
        for (int i = 0; i < NumVC; i++) begin
            if (req[i]) begin
                idx = VcW'(i);
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        for (int i = 0; i < NumVC; i++) begin
            grant[i] = req[i] && (idx == VcW'(i));
        end
    end

endmodule

// File: rtl/ni_tx_sched.sv
// rtl/ni_tx_sched.sv - per-VC TX packet scheduler toward the packet processor; TX_SCHED_RR_EN selects round-robin arbitration
module ni_tx_sched
    import ravenoc_pkg::*;
#(
    parameter int NumVC         = ravenoc_pkg::NumVirtChn,
    parameter int FlitDataWidth = ravenoc_pkg::FlitDataWidth,
    parameter int PktWidth      = ravenoc_pkg::PktWidth,
    localparam int VcW = (NumVC > 1) ? $clog2(NumVC) : 1
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic [NumVC-1:0]               vc_valid_i,
    input  logic [NumVC*FlitDataWidth-1:0] vc_flit_i,
    input  logic [NumVC*PktWidth-1:0]      vc_pkt_sz_i,
    output logic [NumVC-1:0]               vc_ready_o,
    output logic                           pkt_out_valid_o,
    output logic                           pkt_out_req_new_o,
    output logic                           pkt_out_req_last_o,
    output logic [FlitDataWidth-1:0]       pkt_out_flit_o,
    output logic [PktWidth-1:0]            pkt_out_pkt_sz_o,
    output logic [VcW-1:0]                 pkt_out_vc_id_o,
    input  logic                           pkt_out_ready_i,
    output logic                           busy_o,
    output logic [VcW-1:0]                 active_vc_o
);

    tx_sched_st_t       state, next_state;
    logic [PktWidth-1:0] cnt;
    logic [VcW-1:0]      lock_vc;
    logic                pend;

    logic [NumVC-1:0]    arb_grant;
    logic [VcW-1:0]      arb_idx;
    logic [VcW-1:0]      sel;
    logic [NumVC-1:0]    sel_oh;
    logic [PktWidth-1:0] head_sz;
    logic                hs;
    logic                pkt_done;

    ni_vc_arbiter #(.NumVC(NumVC)) u_arb (
        .clk     (clk),
        .arst    (arst),
        .req     (vc_valid_i),
        .update  (pkt_done),
        .upd_idx (sel),
        .grant   (arb_grant),
        .idx     (arb_idx)
    );

    always_comb begin
        sel                = arb_idx;
        sel_oh             = arb_grant;
        pkt_out_valid_o    = 1'b0;
        pkt_out_req_new_o  = 1'b0;
        pkt_out_req_last_o = 1'b0;
        pkt_out_flit_o     = '0;
        pkt_out_pkt_sz_o   = '0;
        pkt_out_vc_id_o    = '0;
        next_state         = state;
        pkt_done           = 1'b0;

        // A locked burst or an unaccepted head keeps the previous grant.
        if (state == TX_BURST || pend) begin
            sel          = lock_vc;
            sel_oh       = '0;
            sel_oh[sel]  = 1'b1;
        end

        head_sz         = vc_pkt_sz_i[sel*PktWidth +: PktWidth];
        pkt_out_valid_o = vc_valid_i[sel];
        hs              = pkt_out_valid_o && pkt_out_ready_i;

        if (pkt_out_valid_o) begin
            pkt_out_flit_o  = vc_flit_i[sel*FlitDataWidth +: FlitDataWidth];
            pkt_out_vc_id_o = sel;
            if (state == TX_IDLE) begin
                pkt_out_req_new_o  = 1'b1;
                pkt_out_pkt_sz_o   = head_sz;
                pkt_out_req_last_o = (head_sz == '0);
            end else begin
                pkt_out_req_last_o = (cnt == PktWidth'(1));
            end
        end

        case (state)
            TX_IDLE: begin
                if (hs && head_sz != '0) begin
                    next_state = TX_BURST;
                end
                pkt_done = hs && (head_sz == '0);
            end
            TX_BURST: begin
                if (hs && cnt == PktWidth'(1)) begin
                    next_state = TX_IDLE;
                    pkt_done   = 1'b1;
                end
            end
            default: next_state = TX_IDLE;
        endcase

        vc_ready_o = hs ? sel_oh : '0;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            lock_vc <= '0;
            pend    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == TX_IDLE) begin
                pend <= pkt_out_valid_o && !pkt_out_ready_i;
                if (pkt_out_valid_o) begin
                    lock_vc <= sel;
                end
                if (hs) begin
                    cnt <= head_sz;
                end
            end else begin
                pend <= 1'b0;
                if (hs && cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign busy_o      = (state == TX_BURST);
    assign active_vc_o = busy_o ? lock_vc : '0;

    a_valid_held: assert property (@(posedge clk) disable iff (arst)
        (pkt_out_valid_o && !pkt_out_ready_i) |=> pkt_out_valid_o);

endmodule

// File: tb/tb_ni_tx_sched.sv
// tb/tb_ni_tx_sched.sv - self-checking bench for ni_tx_sched against a packet-queue model
module tb_ni_tx_sched;

    localparam int NV = 3;
    localparam int FW = 32;
    localparam int PW = 8;
    localparam int VW = 2;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic [NV-1:0]     vc_valid_i = '0;
    logic [NV*FW-1:0]  vc_flit_i = '0;
    logic [NV*PW-1:0]  vc_pkt_sz_i = '0;
    logic [NV-1:0]     vc_ready_o;
    logic              pkt_out_valid_o;
    logic              pkt_out_req_new_o;
    logic              pkt_out_req_last_o;
    logic [FW-1:0]     pkt_out_flit_o;
    logic [PW-1:0]     pkt_out_pkt_sz_o;
    logic [VW-1:0]     pkt_out_vc_id_o;
    logic              pkt_out_ready_i = 1'b0;
    logic              busy_o;
    logic [VW-1:0]     active_vc_o;

    ni_tx_sched #(.NumVC(NV), .FlitDataWidth(FW), .PktWidth(PW)) dut (
        .clk                (clk),
        .arst               (arst),
        .vc_valid_i         (vc_valid_i),
        .vc_flit_i          (vc_flit_i),
        .vc_pkt_sz_i        (vc_pkt_sz_i),
        .vc_ready_o         (vc_ready_o),
        .pkt_out_valid_o    (pkt_out_valid_o),
        .pkt_out_req_new_o  (pkt_out_req_new_o),
        .pkt_out_req_last_o (pkt_out_req_last_o),
        .pkt_out_flit_o     (pkt_out_flit_o),
        .pkt_out_pkt_sz_o   (pkt_out_pkt_sz_o),
        .pkt_out_vc_id_o    (pkt_out_vc_id_o),
        .pkt_out_ready_i    (pkt_out_ready_i),
        .busy_o             (busy_o),
        .active_vc_o        (active_vc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] data;
        int            sz;
        bit            head;
        bit            tail;
    } flit_t;

    typedef struct {
        int vc;
        bit nw;
        bit lst;
        int sz;
        int cyc;
    } xfer_t;

    flit_t q[NV][$];
    xfer_t xlog[$];
    bit    avail[NV];
    bit    rdy = 1'b1;
    bit    rand_mode = 1'b0;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    busy_cycles = 0;
    int    pushed = 0;

    // Model: which packet is open, whether a head is parked, and the RR start point.
    bit    m_busy = 1'b0;
    int    m_vc = 0;
    bit    m_pend = 1'b0;
    int    m_pend_vc = 0;
    int    m_rr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pk(input xfer_t x);
        return x.vc * 1000 + int'(x.nw) * 100 + int'(x.lst) * 10 + x.sz;
    endfunction

    function automatic int arb_pick(input bit [NV-1:0] v);
`ifdef TX_SCHED_RR_EN
        for (int k = 0; k < NV; k++) begin
            if (v[(m_rr + k) % NV]) return (m_rr + k) % NV;
        end
`else
        for (int i = NV - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic push_pkt(input int vc, input int sz);
        for (int i = 0; i <= sz; i++) begin
            q[vc].push_back('{data: $urandom(), sz: (i == 0) ? sz : 0, head: (i == 0), tail: (i == sz)});
            pushed++;
        end
    endtask

    task automatic step();
        bit [NV-1:0] v;
        int          evc;
        bit          ev;
        bit          hs;
        bit          was_busy;
        flit_t       f;
        @(negedge clk);
        if (rand_mode) rdy = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < NV; i++) begin
            v[i] = avail[i] && (q[i].size() > 0);
            vc_valid_i[i] = v[i];
            vc_flit_i[i*FW +: FW]   = v[i] ? q[i][0].data : '0;
            vc_pkt_sz_i[i*PW +: PW] = v[i] ? PW'(q[i][0].sz) : '0;
        end
        pkt_out_ready_i = rdy;
        #1;
        if (m_busy) evc = m_vc;
        else if (m_pend) evc = m_pend_vc;
        else evc = arb_pick(v);
        ev = (evc >= 0) ? v[evc] : 1'b0;
        chk("valid", pkt_out_valid_o, ev);
        if (ev) begin
            f = q[evc][0];
            chk("req_new", pkt_out_req_new_o, f.head);
            chk("req_last", pkt_out_req_last_o, f.tail);
            chk("pkt_sz", pkt_out_pkt_sz_o, f.head ? f.sz : 0);
            chk("vc_id", pkt_out_vc_id_o, evc);
            chk("flit", pkt_out_flit_o, f.data);
        end else begin
            chk("idle_zero", {pkt_out_req_new_o, pkt_out_req_last_o, pkt_out_pkt_sz_o,
                              pkt_out_vc_id_o, pkt_out_flit_o}, 0);
        end
        hs = ev && rdy;
        chk("vc_ready", vc_ready_o, hs ? (64'd1 << evc) : 64'd0);
        chk("busy", busy_o, m_busy);
        chk("active_vc", active_vc_o, m_busy ? m_vc : 0);
        if (busy_o) busy_cycles++;

        was_busy = m_busy;
        if (hs) begin
            void'(q[evc].pop_front());
            xlog.push_back('{vc: evc, nw: f.head, lst: f.tail, sz: f.head ? f.sz : 0, cyc: cyc});
            if (f.head && !f.tail) begin
                m_busy = 1'b1;
                m_vc   = evc;
            end
            if (f.tail) begin
                m_busy = 1'b0;
                m_rr   = (evc + 1) % NV;
            end
        end
        m_pend = !was_busy && ev && !rdy;
        m_pend_vc = evc;
        if (rand_mode) begin
            for (int i = 0; i < NV; i++) begin
                if (!(v[i] && !(hs && evc == i))) avail[i] = ($urandom_range(0, 1) == 1);
            end
        end
        cyc++;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) > 0 && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain_done", q[0].size() + q[1].size() + q[2].size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        for (int i = 0; i < NV; i++) q[i].delete();
        vc_valid_i  = '0;
        vc_flit_i   = '0;
        vc_pkt_sz_i = '0;
        #1;
        chk("rst_valid", pkt_out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_active", active_vc_o, 0);
        chk("rst_ready", vc_ready_o, 0);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        m_busy = 1'b0;
        m_pend = 1'b0;
        m_rr = 0;
        xlog.delete();
        busy_cycles = 0;
        for (int i = 0; i < NV; i++) avail[i] = 1'b1;
        rdy = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int c0;
        int e_first;
        do_reset();

        // Single VC, head plus two flits.
        push_pkt(1, 2);
        drain(20);
        chk("t1_count", xlog.size(), 3);
        chk("t1_x0", pk(xlog[0]), 1102);
        chk("t1_x1", pk(xlog[1]), 1000);
        chk("t1_x2", pk(xlog[2]), 1010);
        chk("t1_busy_cycles", busy_cycles, 2);

        // Two simultaneous heads.
        do_reset();
        push_pkt(0, 1);
        push_pkt(2, 1);
        drain(20);
`ifdef TX_SCHED_RR_EN
        e_first = 0;
`else
        e_first = 2;
`endif
        chk("t2_first_vc", xlog[0].vc, e_first);
        chk("t2_second_pkt_vc", xlog[2].vc, 2 - e_first);
        chk("t2_first_tail", pk(xlog[1]), e_first * 1000 + 10);

        // Locked VC blocks another VC until its tail.
        do_reset();
        push_pkt(2, 3);
        step();
        push_pkt(1, 0);
        drain(20);
        chk("t3_count", xlog.size(), 5);
        chk("t3_tail", pk(xlog[3]), 2010);
        chk("t3_next_head", pk(xlog[4]), 1110);
        chk("t3_next_cycle", xlog[4].cyc, xlog[3].cyc + 1);

        // Zero-size packet followed immediately by another.
        do_reset();
        push_pkt(0, 0);
        push_pkt(0, 1);
        drain(20);
        chk("t4_single", pk(xlog[0]), 110);
        chk("t4_next_head", pk(xlog[1]), 101);
        chk("t4_back_to_back", xlog[1].cyc, xlog[0].cyc + 1);
        chk("t4_busy_cycles", busy_cycles, 1);

        // Back-pressure then underrun in the middle of a packet.
        do_reset();
        push_pkt(1, 3);
        step();
        rdy = 1'b0;
        repeat (4) step();
        rdy = 1'b1;
        step();
        chk("t5_after_bp", xlog.size(), 2);
        avail[1] = 1'b0;
        repeat (3) step();
        chk("t5_underrun", {pkt_out_valid_o, busy_o}, 2'b01);
        avail[1] = 1'b1;
        drain(20);
        chk("t5_count", xlog.size(), 4);
        chk("t5_tail", pk(xlog[3]), 1010);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        push_pkt(2, 5);
        step();
        @(posedge clk);
        #1;
        chk("t6_locked", {busy_o, active_vc_o}, {1'b1, 2'd2});
        do_reset();
        push_pkt(1, 0);
        c0 = cyc;
        step();
        chk("t6_new_head", pk(xlog[0]), 1110);
        chk("t6_immediate", xlog[0].cyc, c0);

        // Randomized traffic.
        do_reset();
        pushed = 0;
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                push_pkt($urandom_range(0, NV - 1),
                         ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3));
            end
            step();
        end
        rand_mode = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < NV; i++) avail[i] = 1'b1;
        drain(6000);
        chk("rand_all_delivered", xlog.size(), pushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
